fsm_split: RTL and testbench

- Transmit-side counterpart of the ordered merge FSM in the decode path.
- Reads one in-order stream of field words from an input FIFO.
- Stamps each word with a running 10-bit field index and dispatches it to either the varint-encoder FIFO or the raw-data FIFO, based on the word's type bit.
- Downstream merge logic uses the index to restore the original order.

---
 rtl/fsm_split.sv | 199 +++++++++++++++++++
 tb/tb_fsm_split.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_split.sv
`default_nettype none
// ============================================================================
// Module   : fsm_split
// Purpose  : Transmit-side splitter. Pops an ordered stream of field words
//            from an input FIFO, stamps each with a running field index and
//            pushes it to the varint-encoder FIFO or to the raw-data FIFO,
//            chosen by the word's type bit. The downstream merge uses the
//            index to restore the original order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_W  width of a field data word
//   IDX_W   width of the field index (matches the downstream index FIFOs)
// Ports:
//   clk               system clock
//   reset             asynchronous, active-low reset
//   enable            low: go idle at the next word boundary
//   in_fifo_empty     input FIFO empty flag
//   in_fifo_pop       input FIFO read strobe (data valid one cycle later)
//   in_fifo_q         input word {last, is_varint, data}
//   varint_fifo_full  varint FIFO full flag
//   varint_fifo_push  varint FIFO write strobe
//   varint_index_d    index written with a varint word
//   varint_data_d     varint data
//   raw_fifo_full     raw FIFO full flag
//   raw_fifo_push     raw FIFO write strobe
//   raw_index_d       index written with a raw word
//   raw_data_d        raw data
//   msg_done          one-cycle pulse after the last word of a message
// Optional (macro FSM_SPLIT_STATS_EN):
//   varint_count      saturating count of varint pushes since reset
//   raw_count         saturating count of raw pushes since reset
// ============================================================================
module fsm_split #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_fifo_empty,
  output logic              in_fifo_pop,
  input  logic [DATA_W+1:0] in_fifo_q,
  input  logic              varint_fifo_full,
  output logic              varint_fifo_push,
  output logic [IDX_W-1:0]  varint_index_d,
  output logic [DATA_W-1:0] varint_data_d,
  input  logic              raw_fifo_full,
  output logic              raw_fifo_push,
  output logic [IDX_W-1:0]  raw_index_d,
  output logic [DATA_W-1:0] raw_data_d,
  output logic              msg_done
`ifdef FSM_SPLIT_STATS_EN
  ,
  output logic [15:0]       varint_count,
  output logic [15:0]       raw_count
`endif
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_POP      = 3'd1;
  localparam logic [2:0] c_WAIT     = 3'd2;
  localparam logic [2:0] c_DISPATCH = 3'd3;
  localparam logic [2:0] c_DONE     = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic             r_last;
  logic             r_type;
  logic [IDX_W-1:0] r_out_index;
  logic             w_target_full;
  logic             w_push;
  logic             w_can_pop;

  // Only the FIFO the held word is going to can stall the dispatch.
  assign w_target_full = r_type ? varint_fifo_full : raw_fifo_full;
  assign w_push        = (r_state == c_DISPATCH) && !w_target_full;
  assign w_can_pop     = enable && !in_fifo_empty;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_can_pop) begin
          w_next_state = c_POP;
        end
      end
      c_POP: begin
        w_next_state = c_WAIT;
      end
      c_WAIT: begin
        w_next_state = c_DISPATCH;
      end
      c_DISPATCH: begin
        if (!w_target_full) begin
          if (r_last) begin
            w_next_state = c_DONE;
          end else if (w_can_pop) begin
            w_next_state = c_POP;
          end else begin
            w_next_state = c_IDLE;
          end
        end
      end
      c_DONE: begin
        w_next_state = c_IDLE;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    in_fifo_pop      = (r_state == c_POP);
    varint_fifo_push = w_push && r_type;
    raw_fifo_push    = w_push && !r_type;
    msg_done         = (r_state == c_DONE);
  end

  // --------------------------------------------------------------------------
  // Word capture. The selected path's index/data registers double as the
  // data holding register: they are loaded in WAIT, so they are already
  // stable for the whole of DISPATCH (including any full stall), while the
  // other path keeps its previous contents. The index cannot change between
  // WAIT and DISPATCH, so loading it early gives the pre-increment value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last         <= 1'b0;
      r_type         <= 1'b0;
      varint_index_d <= '0;
      varint_data_d  <= '0;
      raw_index_d    <= '0;
      raw_data_d     <= '0;
    end else if (r_state == c_WAIT) begin
      r_last <= in_fifo_q[DATA_W+1];
      r_type <= in_fifo_q[DATA_W];
      if (in_fifo_q[DATA_W]) begin
        varint_index_d <= r_out_index;
        varint_data_d  <= in_fifo_q[DATA_W-1:0];
      end else begin
        raw_index_d <= r_out_index;
        raw_data_d  <= in_fifo_q[DATA_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Running field index: wraps naturally at 2^IDX_W, restarts per message.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_index <= '0;
    end else if (w_push) begin
      r_out_index <= r_out_index + 1'b1;
    end else if (r_state == c_DONE) begin
      r_out_index <= '0;
    end
  end

`ifdef FSM_SPLIT_STATS_EN
  // --------------------------------------------------------------------------
  // Push statistics, saturating, cleared by reset only.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      varint_count <= '0;
      raw_count    <= '0;
    end else begin
      if (varint_fifo_push && (varint_count != 16'hFFFF)) begin
        varint_count <= varint_count + 16'd1;
      end
      if (raw_fifo_push && (raw_count != 16'hFFFF)) begin
        raw_count <= raw_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_split
// Purpose  : Directed self-checking bench for fsm_split. An array-backed
//            input FIFO model feeds words; a negedge monitor records every
//            push (path, index, data, cycle) and every pop cycle, and the
//            directed sequence compares them with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_split;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_fifo_empty;
  logic        in_fifo_pop;
  logic [65:0] in_fifo_q = '0;
  logic        varint_fifo_full;
  logic        varint_fifo_push;
  logic [9:0]  varint_index_d;
  logic [63:0] varint_data_d;
  logic        raw_fifo_full;
  logic        raw_fifo_push;
  logic [9:0]  raw_index_d;
  logic [63:0] raw_data_d;
  logic        msg_done;
`ifdef FSM_SPLIT_STATS_EN
  logic [15:0] varint_count;
  logic [15:0] raw_count;
`endif

  always #5 clk = ~clk;

  fsm_split #(.DATA_W(64), .IDX_W(10)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .in_fifo_empty    (in_fifo_empty),
    .in_fifo_pop      (in_fifo_pop),
    .in_fifo_q        (in_fifo_q),
    .varint_fifo_full (varint_fifo_full),
    .varint_fifo_push (varint_fifo_push),
    .varint_index_d   (varint_index_d),
    .varint_data_d    (varint_data_d),
    .raw_fifo_full    (raw_fifo_full),
    .raw_fifo_push    (raw_fifo_push),
    .raw_index_d      (raw_index_d),
    .raw_data_d       (raw_data_d),
    .msg_done         (msg_done)
`ifdef FSM_SPLIT_STATS_EN
    ,
    .varint_count     (varint_count),
    .raw_count        (raw_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Input FIFO model: the bench writes src_mem, the DUT pops it.
  logic [65:0] src_mem [0:2047];
  int wr_cnt = 0;
  int rd_cnt = 0;

  assign in_fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (in_fifo_pop) begin
      in_fifo_q <= src_mem[rd_cnt[10:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Monitor
  typedef struct {
    logic        v;
    logic [9:0]  idx;
    logic [63:0] data;
    int          cyc;
  } rec_t;

  rec_t pq[$];
  int   popq[$];
  rec_t mon_rec;
  int   done_cnt      = 0;
  int   pop_empty_cnt = 0;
  int   both_cnt      = 0;
  int   overlap_cnt   = 0;

  always @(negedge clk) begin
    if (varint_fifo_push) begin
      mon_rec.v = 1'b1; mon_rec.idx = varint_index_d;
      mon_rec.data = varint_data_d; mon_rec.cyc = cyc;
      pq.push_back(mon_rec);
    end
    if (raw_fifo_push) begin
      mon_rec.v = 1'b0; mon_rec.idx = raw_index_d;
      mon_rec.data = raw_data_d; mon_rec.cyc = cyc;
      pq.push_back(mon_rec);
    end
    if (varint_fifo_push && raw_fifo_push) both_cnt++;
    if (in_fifo_pop) popq.push_back(cyc);
    if (in_fifo_pop && in_fifo_empty) pop_empty_cnt++;
    if (in_fifo_pop && (varint_fifo_push || raw_fifo_push)) overlap_cnt++;
    if (msg_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic add_word(input logic last, input logic isv, input logic [63:0] d);
    src_mem[wr_cnt[10:0]] = {last, isv, d};
    wr_cnt++;
  endtask

  task automatic wait_pushes(input int n, input int budget, input string tag);
    int k = 0;
    while (pq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(pq.size()), 64'(n));
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (popq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(popq.size()), 64'(n));
  endtask

  task automatic check_rec(input int i, input string tag, input logic v,
                           input logic [9:0] idx, input logic [63:0] d);
    if (i < pq.size()) begin
      check({tag, "_type"}, 64'(pq[i].v), 64'(v));
      check({tag, "_idx"}, 64'(pq[i].idx), 64'(idx));
      check({tag, "_data"}, pq[i].data, d);
    end else begin
      check({tag, "_missing"}, 64'(pq.size()), 64'(i + 1));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({in_fifo_pop, varint_fifo_push, raw_fifo_push, msg_done}), 64'd0);
    check({tag, "_vidx"}, 64'(varint_index_d), 64'd0);
    check({tag, "_vdata"}, varint_data_d, 64'd0);
    check({tag, "_ridx"}, 64'(raw_index_d), 64'd0);
    check({tag, "_rdata"}, raw_data_d, 64'd0);
  endtask

  initial begin
    int d0;
    int fall;
    int bad;
    int npair;

    reset            = 1'b0;
    enable           = 1'b0;
    varint_fifo_full = 1'b0;
    raw_fifo_full    = 1'b0;
    ticks(3);
    check_zero("rst");
`ifdef FSM_SPLIT_STATS_EN
    check("rst_vcount", 64'(varint_count), 64'd0);
    check("rst_rcount", 64'(raw_count), 64'd0);
`endif
    reset  = 1'b1;
    enable = 1'b1;
    ticks(2);

    // ---- three-word message, then a new message restarts at index 0 ----
    pq.delete(); popq.delete(); d0 = done_cnt;
    add_word(1'b0, 1'b1, 64'hA1A1_0000_0000_0001);
    add_word(1'b0, 1'b0, 64'hB2B2_0000_0000_0002);
    add_word(1'b1, 1'b1, 64'hC3C3_0000_0000_0003);
    wait_pushes(3, 40, "t1_cnt");
    check_rec(0, "t1_w0", 1'b1, 10'd0, 64'hA1A1_0000_0000_0001);
    check_rec(1, "t1_w1", 1'b0, 10'd1, 64'hB2B2_0000_0000_0002);
    check_rec(2, "t1_w2", 1'b1, 10'd2, 64'hC3C3_0000_0000_0003);
    ticks(3);
    check("t1_done", 64'(done_cnt - d0), 64'd1);
    add_word(1'b1, 1'b0, 64'hD4D4_0000_0000_0004);
    wait_pushes(4, 20, "t1_cnt2");
    check_rec(3, "t1_w3", 1'b0, 10'd0, 64'hD4D4_0000_0000_0004);
    ticks(3);

    // ---- raw FIFO full for 10 cycles while a raw word is in DISPATCH ----
    pq.delete(); popq.delete();
    raw_fifo_full = 1'b1;
    add_word(1'b0, 1'b0, 64'h5555_5555_0000_0001);
    add_word(1'b1, 1'b1, 64'h6666_6666_0000_0002);
    wait_pops(1, 20, "t2_pop");
    ticks(2);
    check("t2_rdata_held", raw_data_d, 64'h5555_5555_0000_0001);
    ticks(10);
    check("t2_nopush", 64'(pq.size()), 64'd0);
    check("t2_nopop", 64'(popq.size()), 64'd1);
    check("t2_rdata_stable", raw_data_d, 64'h5555_5555_0000_0001);
    check("t2_ridx_stable", 64'(raw_index_d), 64'd0);
    @(posedge clk);
    #1;
    raw_fifo_full = 1'b0;
    fall = cyc;
    wait_pushes(1, 5, "t2_push");
    check_rec(0, "t2_w0", 1'b0, 10'd0, 64'h5555_5555_0000_0001);
    if (pq.size() > 0) check("t2_push_cyc", 64'(pq[0].cyc), 64'(fall));
    wait_pushes(2, 20, "t2_push2");
    check_rec(1, "t2_w1", 1'b1, 10'd1, 64'h6666_6666_0000_0002);
    ticks(3);

    // ---- varint FIFO full does not stall a raw word ----
    pq.delete(); popq.delete();
    varint_fifo_full = 1'b1;
    add_word(1'b1, 1'b0, 64'h7777_0000_0000_0007);
    wait_pushes(1, 20, "t3_push");
    check_rec(0, "t3_w0", 1'b0, 10'd0, 64'h7777_0000_0000_0007);
    if (pq.size() > 0 && popq.size() > 0)
      check("t3_spacing", 64'(pq[0].cyc - popq[0]), 64'd2);
    ticks(3);
    varint_fifo_full = 1'b0;

    // ---- 1030 words: index wrap 1023 -> 0, pop-to-push spacing ----
    pq.delete(); popq.delete();
    for (int i = 0; i < 1030; i++) add_word(1'b0, i[0], 64'h4000_0000_0000_0000 + 64'(i));
    add_word(1'b1, 1'b0, 64'h4FFF_FFFF_FFFF_FFFF);
    wait_pushes(1031, 4000, "t4_cnt");
    for (int i = 0; i < 1030; i++)
      check_rec(i, "t4_w", i[0], 10'(i % 1024), 64'h4000_0000_0000_0000 + 64'(i));
    check_rec(1030, "t4_last", 1'b0, 10'd6, 64'h4FFF_FFFF_FFFF_FFFF);
    check("t4_pops", 64'(popq.size()), 64'd1031);
    bad   = 0;
    npair = (pq.size() < popq.size()) ? pq.size() : popq.size();
    for (int i = 0; i < npair; i++) if (pq[i].cyc - popq[i] != 2) bad++;
    check("t4_spacing_bad", 64'(bad), 64'd0);
    ticks(3);

    // ---- enable dropped while idx 4 is in WAIT ----
    pq.delete(); popq.delete();
    for (int i = 0; i < 6; i++) add_word(1'b0, i[0], 64'h5000 + 64'(i));
    wait_pops(5, 40, "t5_pop5");
    @(posedge clk);
    #1;
    enable = 1'b0;
    ticks(8);
    check("t5_pushes_idle", 64'(pq.size()), 64'd5);
    check("t5_pops_idle", 64'(popq.size()), 64'd5);
    check_rec(4, "t5_w4", 1'b0, 10'd4, 64'h5004);
    enable = 1'b1;
    wait_pushes(6, 20, "t5_resume");
    check_rec(5, "t5_w5", 1'b1, 10'd5, 64'h5005);
    add_word(1'b1, 1'b0, 64'h5FFF);
    wait_pushes(7, 20, "t5_close");
    check_rec(6, "t5_w6", 1'b0, 10'd6, 64'h5FFF);
    ticks(3);

    // ---- asynchronous reset while a raw word stalls in DISPATCH ----
    pq.delete(); popq.delete();
    raw_fifo_full = 1'b1;
    add_word(1'b0, 1'b1, 64'h6001);
    add_word(1'b0, 1'b0, 64'h6002_ABCD);
    wait_pops(2, 30, "t6_pop2");
    ticks(2);
    check("t6_rdata_pre", raw_data_d, 64'h6002_ABCD);
    check("t6_ridx_pre", 64'(raw_index_d), 64'd1);
    check("t6_push_pre", 64'(pq.size()), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("t6_rst");
`ifdef FSM_SPLIT_STATS_EN
    check("t6_vcount", 64'(varint_count), 64'd0);
    check("t6_rcount", 64'(raw_count), 64'd0);
`endif
    tick();
    reset         = 1'b1;
    raw_fifo_full = 1'b0;
    ticks(3);
    check("t6_nopush", 64'(pq.size()), 64'd1);
    add_word(1'b0, 1'b1, 64'h6003);
    wait_pushes(2, 20, "t6_after_cnt");
    check_rec(1, "t6_after", 1'b1, 10'd0, 64'h6003);
`ifdef FSM_SPLIT_STATS_EN
    check("t6_vcount_after", 64'(varint_count), 64'd1);
    check("t6_rcount_after", 64'(raw_count), 64'd0);
`endif
    ticks(3);

    // ---- global protocol invariants ----
    check("pop_while_empty", 64'(pop_empty_cnt), 64'd0);
    check("both_pushes", 64'(both_cnt), 64'd0);
    check("pop_with_push", 64'(overlap_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
